// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. It scans ROW/COLUMN over the full
// frame (active, front porch, sync, back porch for both axes), uses them as the
// framebuffer fetch address and registers the returned pixel together with
// HSYNC/VSYNC/ACTIVE. The sync and active flags are delayed by RD_LAT clocks
// so that pixel data from a framebuffer with RD_LAT-cycle read latency is
// aligned with the sync pulses at the pins. Total latency from a coordinate on
// ROW/COLUMN to the matching pin outputs is RD_LAT+1 clocks.
//
// Optional feature macro: VGA_BORDER_EN
//   When defined, a BORDER_COLOR parameter is added. Active pixels on the first
//   or last visible row or column are replaced by BORDER_COLOR, split MSB-first
//   into R, G, B. When undefined, pixel data passes through unchanged.
//
// Ports:
//   CLK        in   pixel clock
//   RST        in   asynchronous reset, active-high
//   RED        in   framebuffer red   (for coordinate issued RD_LAT clocks ago)
//   GREEN      in   framebuffer green
//   BLUE       in   framebuffer blue
//   ROW        out  line counter   (framebuffer fetch address)
//   COLUMN     out  column counter (framebuffer fetch address)
//   ROUT       out  red to pins
//   GOUT       out  green to pins
//   BOUT       out  blue to pins
//   HSYNC      out  horizontal sync, HS_POL during the pulse
//   VSYNC      out  vertical sync,   VS_POL during the pulse
//   ACTIVE     out  pin-side pixel is visible, aligned with ROUT/GOUT/BOUT
//   VBLANK_IRQ out  one-clock pulse at the start of vertical blank
//
// RD_LAT is expected in the range 0..4. H_W/V_W must hold H_TOTAL-1/V_TOTAL-1.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    parameter int RD_LAT   = 1,
    parameter int H_W      = 10,
    parameter int V_W      = 10
`ifdef VGA_BORDER_EN
    ,
    parameter logic [R_W+G_W+B_W-1:0] BORDER_COLOR = '1
`endif
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [R_W-1:0] RED,
    input  logic [G_W-1:0] GREEN,
    input  logic [B_W-1:0] BLUE,
    output logic [V_W-1:0] ROW,
    output logic [H_W-1:0] COLUMN,
    output logic [R_W-1:0] ROUT,
    output logic [G_W-1:0] GOUT,
    output logic [B_W-1:0] BOUT,
    output logic           HSYNC,
    output logic           VSYNC,
    output logic           ACTIVE,
    output logic           VBLANK_IRQ
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

    // Flag vector carried down the latency pipeline.
    // bit 0 = vs, bit 1 = hs, bit 2 = act (, bit 3 = border).
    localparam int F_VS  = 0;
    localparam int F_HS  = 1;
    localparam int F_ACT = 2;
`ifdef VGA_BORDER_EN
    localparam int F_BRD = 3;
    localparam int NF    = 4;
`else
    localparam int NF    = 3;
`endif

    // ---------------------------------------------------------------- counters
    logic [H_W-1:0] col_q, col_d;
    logic [V_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q + H_W'(1);
        row_d = row_q;
        if (col_q == H_LAST) begin
            col_d = '0;
            // Row only moves on the column wrap clock, so the frame wrap
            // (row V_TOTAL-1 -> 0) coincides with the column wrap.
            row_d = (row_q == V_LAST) ? '0 : row_q + V_W'(1);
        end
    end

    // ----------------------------------------------------------- stage-0 decode
    logic          act0;
    logic          hs0;
    logic          vs0;
    logic [NF-1:0] flags0;
`ifdef VGA_BORDER_EN
    logic          brd0;
`endif

    always_comb begin
        // Compare in 32 bits so that range ends equal to H_TOTAL/V_TOTAL
        // cannot overflow the counter width.
        act0 = (32'(col_q) < H_ACTIVE) && (32'(row_q) < V_ACTIVE);
        hs0  = (32'(col_q) >= H_ACTIVE + H_FP) &&
               (32'(col_q) <  H_ACTIVE + H_FP + H_SYNC);
        vs0  = (32'(row_q) >= V_ACTIVE + V_FP) &&
               (32'(row_q) <  V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_BORDER_EN
        brd0 = act0 && ((32'(col_q) == 0) || (32'(col_q) == H_ACTIVE - 1) ||
                        (32'(row_q) == 0) || (32'(row_q) == V_ACTIVE - 1));
        flags0 = {brd0, act0, hs0, vs0};
`else
        flags0 = {act0, hs0, vs0};
`endif
    end

    // ------------------------------------------------------ latency pipeline
    logic [NF-1:0] flags_dly;

    generate
        if (RD_LAT == 0) begin : g_no_lat
            assign flags_dly = flags0;
        end else begin : g_lat
            logic [NF-1:0] pipe_q [RD_LAT];

            // Cleared stages mean inactive / no-sync, so the pins hold the
            // deassert level until real decode reaches them.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < RD_LAT; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= flags0;
                    for (int i = 1; i < RD_LAT; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign flags_dly = pipe_q[RD_LAT-1];
        end
    endgenerate

    // ---------------------------------------------------------- output stage
    logic [R_W-1:0] rout_q, rout_d;
    logic [G_W-1:0] gout_q, gout_d;
    logic [B_W-1:0] bout_q, bout_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           active_q, active_d;
    logic           vblank_q, vblank_d;

    always_comb begin
        rout_d   = '0;
        gout_d   = '0;
        bout_d   = '0;
        active_d = flags_dly[F_ACT];
        hsync_d  = flags_dly[F_HS] ? HS_POL : ~HS_POL;
        vsync_d  = flags_dly[F_VS] ? VS_POL : ~VS_POL;
        // Framebuffer data is ignored outside the visible area.
        if (flags_dly[F_ACT]) begin
            rout_d = RED;
            gout_d = GREEN;
            bout_d = BLUE;
`ifdef VGA_BORDER_EN
            if (flags_dly[F_BRD]) begin
                {rout_d, gout_d, bout_d} = BORDER_COLOR;
            end
`endif
        end
        // Taken straight from the counters: the interrupt is not
        // latency-delayed, it fires the clock after (V_ACTIVE, 0).
        vblank_d = (32'(row_q) == V_ACTIVE) && (col_q == '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col_q    <= '0;
            row_q    <= '0;
            rout_q   <= '0;
            gout_q   <= '0;
            bout_q   <= '0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            active_q <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            rout_q   <= rout_d;
            gout_q   <= gout_d;
            bout_q   <= bout_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            vblank_q <= vblank_d;
        end
    end

    assign ROW        = row_q;
    assign COLUMN     = col_q;
    assign ROUT       = rout_q;
    assign GOUT       = gout_q;
    assign BOUT       = bout_q;
    assign HSYNC      = hsync_q;
    assign VSYNC      = vsync_q;
    assign ACTIVE     = active_q;
    assign VBLANK_IRQ = vblank_q;

endmodule
